// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues LDR/STR(B) over a req/ack handshake.
// Optional MEM_TIMEOUT_EN aborts an access that waits too long for mem_ack.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [31:0] inst_in,
  input  logic [31:0] cpsr_in,
  input  logic [31:0] result_in,
  input  logic [31:0] storedata_in,
  input  logic [31:0] pc_in,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] inst,
  output logic [31:0] cpsr,
  output logic [31:0] result,
  output logic [31:0] memdata,
  output logic [31:0] pc,
  output logic        mem_err
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] cpsr;
    logic [31:0] result;
    logic [31:0] memdata;
    logic [31:0] pc;
  } wb_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] cpsr;
    logic [31:0] result;
    logic [31:0] sdata;
    logic [31:0] pc;
  } lat_t;

  function automatic logic cond_pass(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0:    cond_pass = z;
      4'h1:    cond_pass = !z;
      4'h2:    cond_pass = cf;
      4'h3:    cond_pass = !cf;
      4'h4:    cond_pass = n;
      4'h5:    cond_pass = !n;
      4'h6:    cond_pass = v;
      4'h7:    cond_pass = !v;
      4'h8:    cond_pass = cf & !z;
      4'h9:    cond_pass = !cf | z;
      4'hA:    cond_pass = (n == v);
      4'hB:    cond_pass = (n != v);
      4'hC:    cond_pass = !z & (n == v);
      4'hD:    cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  logic [0:0] state_q, state_d;
  wb_t        out_q, out_d;
  lat_t       lat_q, lat_d;
  logic       in_go;
  logic       l_load, l_byte;
  logic [1:0] lane;
  logic [31:0] ld_data;
  logic       to_hit;

  assign in_go  = (inst_in[27:26] == 2'b01)
                & cond_pass(inst_in[31:28], cpsr_in[31:28]);
  assign l_load = lat_q.inst[20];
  assign l_byte = lat_q.inst[22];
  assign lane   = lat_q.result[1:0];

  always_comb begin
    ld_data = mem_rdata;
    if (l_byte) begin
      case (lane)
        2'd0:    ld_data = {24'b0, mem_rdata[7:0]};
        2'd1:    ld_data = {24'b0, mem_rdata[15:8]};
        2'd2:    ld_data = {24'b0, mem_rdata[23:16]};
        default: ld_data = {24'b0, mem_rdata[31:24]};
      endcase
    end
  end

  // Everything toward memory is driven only from the latched copy.
  assign mem_req   = (state_q == WAIT);
  assign stall     = mem_req;
  assign mem_we    = mem_req & ~l_load;
  assign mem_addr  = mem_req ? {lat_q.result[31:2], 2'b00} : 32'd0;
  assign mem_be    = !mem_req ? 4'b0000 :
                     l_byte   ? (4'b0001 << lane) : 4'b1111;
  assign mem_wdata = !mem_req ? 32'd0 :
                     l_byte   ? {4{lat_q.sdata[7:0]}} : lat_q.sdata;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    out_d   = '0;
    if (state_q == RUN) begin
      if (valid_in && in_go) begin
        lat_d   = '{inst_in, cpsr_in, result_in, storedata_in, pc_in};
        state_d = WAIT;
      end else if (valid_in) begin
        out_d = '{inst_in, cpsr_in, result_in, 32'd0, pc_in};
      end
    end else if (mem_ack || to_hit) begin
      out_d.inst    = lat_q.inst;
      out_d.cpsr    = lat_q.cpsr;
      out_d.result  = lat_q.result;
      out_d.pc      = lat_q.pc;
      out_d.memdata = !l_load ? 32'd0 :
                      mem_ack ? ld_data : 32'hDEADBEEF;
      state_d       = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      lat_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      out_q   <= out_d;
    end
  end

  assign inst    = out_q.inst;
  assign cpsr    = out_q.cpsr;
  assign result  = out_q.result;
  assign memdata = out_q.memdata;
  assign pc      = out_q.pc;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Counter is held at zero in RUN so each access starts from zero.
  assign to_hit = (state_q == WAIT) & ~mem_ack
                & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = (state_q == WAIT) ? cnt_q + CW'(1) : '0;
    err_d = err_q | to_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_err = err_q;
`else
  logic unused_cfg;

  assign unused_cfg = |TIMEOUT_CYCLES;
  assign to_hit     = 1'b0;
  assign mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random ops
// against a rule-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] inst_in, cpsr_in, result_in, storedata_in, pc_in;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [31:0] inst, cpsr, result, memdata, pc;
  logic        mem_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .inst_in(inst_in), .cpsr_in(cpsr_in),
    .result_in(result_in), .storedata_in(storedata_in),
    .pc_in(pc_in), .stall(stall), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .inst(inst), .cpsr(cpsr),
    .result(result), .memdata(memdata), .pc(pc),
    .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond_ok(input logic [3:0] c,
                                 input logic [31:0] f);
    bit n, z, cf, v;
    n = f[31]; z = f[30]; cf = f[29]; v = f[28];
    case (c)
      0: return z;
      1: return !z;
      2: return cf;
      3: return !cf;
      4: return n;
      5: return !n;
      6: return v;
      7: return !v;
      8: return cf && !z;
      9: return !cf || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk_out(input string tag, input logic [31:0] i,
                         input logic [31:0] c, input logic [31:0] r,
                         input logic [31:0] md, input logic [31:0] p);
    chk({tag, ".inst"}, inst, i);
    chk({tag, ".cpsr"}, cpsr, c);
    chk({tag, ".result"}, result, r);
    chk({tag, ".memdata"}, memdata, md);
    chk({tag, ".pc"}, pc, p);
  endtask

  // Present one instruction; for a memory op answer after k wait cycles.
  task automatic run_op(input string tag, input logic [31:0] i,
                        input logic [31:0] c, input logic [31:0] r,
                        input logic [31:0] sd, input logic [31:0] p,
                        input int k, input logic [31:0] rd);
    bit is_mem, ld, by;
    int lane;
    logic [31:0] exp_md, exp_wd;
    logic [3:0]  exp_be;
    is_mem = (i[27:26] == 2'b01) && cond_ok(i[31:28], c);
    ld   = i[20];
    by   = i[22];
    lane = int'(r[1:0]);
    exp_be = by ? 4'(1 << lane) : 4'hF;
    exp_wd = by ? {4{sd[7:0]}} : sd;
    exp_md = !ld ? 32'd0 :
             by  ? ((rd >> (8 * lane)) & 32'hFF) : rd;
    valid_in = 1'b1;
    inst_in = i; cpsr_in = c; result_in = r;
    storedata_in = sd; pc_in = p;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    step();
    if (!is_mem) begin
      chk_out(tag, i, c, r, 32'd0, p);
      chk({tag, ".stall"}, stall, 0);
      chk({tag, ".req"}, mem_req, 0);
    end else begin
      inst_in = $urandom; result_in = $urandom;
      storedata_in = $urandom;
      mem_ack = 1'b0;
      for (int w = 1; w <= k; w++) begin
        chk({tag, ".wstall"}, stall, 1);
        chk({tag, ".wreq"}, mem_req, 1);
        chk({tag, ".we"}, mem_we, !ld);
        chk({tag, ".addr"}, mem_addr, {r[31:2], 2'b00});
        chk({tag, ".be"}, mem_be, exp_be);
        if (!ld) chk({tag, ".wdata"}, mem_wdata, exp_wd);
        chk({tag, ".bubble"}, inst, 0);
        if (w == k) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        step();
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      chk_out(tag, i, c, r, exp_md, p);
      chk({tag, ".stall_end"}, stall, 0);
      chk({tag, ".req_end"}, mem_req, 0);
    end
    valid_in = 1'b0;
  endtask

  initial begin
    logic [31:0] ri, rc;
    rst_n = 1'b0;
    valid_in = 1'b0;
    inst_in = '0; cpsr_in = '0; result_in = '0;
    storedata_in = '0; pc_in = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    step();
    step();
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.stall", stall, 0);
    chk("reset.req", mem_req, 0);
    chk("reset.err", mem_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_op("add", 32'hE0812003, 32'h0, 32'd5, 32'd0,
           32'h40, 1, 32'd0);
    run_op("ldr", 32'hE5912000, 32'h0, 32'h100, 32'd0,
           32'h44, 3, 32'hCAFEF00D);
    run_op("strb", 32'hE5C12000, 32'h0, 32'h103,
           32'h1234_56AB, 32'h48, 2, 32'h0);
    run_op("ldrb", 32'hE5D12000, 32'h0, 32'h102, 32'd0,
           32'h4C, 1, 32'h11223344);
    run_op("ldreq", 32'h05912000, 32'h0, 32'h200, 32'd0,
           32'h50, 1, 32'h0);
    run_op("ldreq_z", 32'h05912000, 32'h4000_0000, 32'h204,
           32'd0, 32'h54, 1, 32'h55667788);
    valid_in = 1'b0;
    step();
    chk_out("idle", 0, 0, 0, 0, 0);

    // Asynchronous reset while an access is outstanding.
    valid_in = 1'b1;
    inst_in = 32'hE5912000; result_in = 32'h300;
    step();
    valid_in = 1'b0;
    chk("arst.req_before", mem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.req", mem_req, 0);
    chk("arst.stall", stall, 0);
    chk_out("arst", 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst.req_after", mem_req, 0);

`ifdef MEM_TIMEOUT_EN
    valid_in = 1'b1;
    inst_in = 32'hE5912000; cpsr_in = 32'h0;
    result_in = 32'h104; pc_in = 32'h60;
    step();
    valid_in = 1'b0;
    for (int w = 0; w < 16; w++) begin
      chk("tmo.stall", stall, 1);
      step();
    end
    chk_out("tmo", 32'hE5912000, 0, 32'h104, 32'hDEADBEEF, 32'h60);
    chk("tmo.err", mem_err, 1);
    chk("tmo.req", mem_req, 0);
    step();
    chk("tmo.err_sticky", mem_err, 1);
`else
    run_op("slow", 32'hE5912000, 32'h0, 32'h108, 32'd0,
           32'h60, 20, 32'h0BAD_F00D);
    chk("noerr", mem_err, 0);
`endif

    for (int n = 0; n < 60; n++) begin
      ri = $urandom;
      rc = $urandom;
      if ($urandom_range(0, 2) != 0) ri[27:26] = 2'b01;
      run_op("rand", ri, rc, $urandom, $urandom, $urandom,
             int'($urandom_range(1, 4)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        step();
        chk_out("rand.idle", 0, 0, 0, 0, 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
